// File: rtl/arp_data_tx_if.sv
// Byte-stream handshake between the ARP payload transmitter and the frame builder.
// The master drives the byte, valid and last flags. The slave returns ready.
interface arp_data_tx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       data_last;

  modport master (
    output data_out,
    output data_valid,
    output data_last,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  data_last,
    output data_ready
  );
endinterface

// File: rtl/arp_data_tx.sv
// ARP payload transmitter. On a start strobe it latches the fields, then streams the
// 28-byte ARP payload and PAD_LEN zero bytes, MSB byte first, over a valid/ready handshake.
module arp_data_tx #(
  parameter int unsigned PAD_LEN = 18
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          arp_tx_start,
  input  logic          arp_oper,
  input  logic [47:0]   mac_s_addr,
  input  logic [31:0]   ip_s_addr,
  input  logic [47:0]   mac_d_addr,
  input  logic [31:0]   ip_d_addr,
  arp_data_tx_if.master tx,
  output logic          arp_tx_busy,
  output logic          arp_tx_done
);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StMacSource,
    StIpSource,
    StMacDestination,
    StIpDestination,
    StPad
  } state_e;

  localparam logic [5:0] PadLast    = 6'(PAD_LEN == 0 ? 0 : PAD_LEN - 1);
  localparam state_e     FinalState = (PAD_LEN == 0) ? StIpDestination : StPad;

  state_e         state_q, state_d, state_next;
  logic [5:0]     cnt_q, cnt_d, cnt_max;
  logic [223:0]   frame_q, frame_d;
  logic           done_q, done_d;
  logic           valid, xfer, state_end;

  // The whole payload is captured at start and shifted out one byte per transfer.
  // Zeros shift in behind it, so the pad bytes and the idle output are zero.
  assign valid     = (state_q != StIdle);
  assign xfer      = valid && tx.data_ready;
  assign state_end = valid && (cnt_q == cnt_max);

  always_comb begin
    cnt_max    = 6'd0;
    state_next = StIdle;
    case (state_q)
      StHeader:         begin cnt_max = 6'd7; state_next = StMacSource;      end
      StMacSource:      begin cnt_max = 6'd5; state_next = StIpSource;       end
      StIpSource:       begin cnt_max = 6'd3; state_next = StMacDestination; end
      StMacDestination: begin cnt_max = 6'd5; state_next = StIpDestination;  end
      StIpDestination:  begin
        cnt_max    = 6'd3;
        state_next = (PAD_LEN == 0) ? StIdle : StPad;
      end
      StPad:            begin cnt_max = PadLast; state_next = StIdle;        end
      default:          begin cnt_max = 6'd0; state_next = StIdle;           end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    if (state_q == StIdle) begin
      if (arp_tx_start) begin
        state_d = StHeader;
        cnt_d   = 6'd0;
        frame_d = {16'h0001, 16'h0800, 8'h06, 8'h04, 14'h0000, arp_oper, ~arp_oper,
                   mac_s_addr, ip_s_addr, (arp_oper ? mac_d_addr : 48'h0), ip_d_addr};
      end
    end else if (xfer) begin
      frame_d = {frame_q[215:0], 8'h00};
      if (state_end) begin
        cnt_d   = 6'd0;
        state_d = state_next;
        done_d  = (state_q == FinalState);
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

  assign tx.data_out   = frame_q[223:216];
  assign tx.data_valid = valid;
  assign tx.data_last  = state_end && (state_q == FinalState);
  assign arp_tx_busy   = valid;
  assign arp_tx_done   = done_q;

endmodule

// File: doc/arp_data_tx.md
Name: arp_data_tx

Overview:
ARP payload transmitter, the transmit-direction counterpart of the ARP receive parser. On a start strobe it latches the operation and the four address fields, then serialises the 28-byte ARP payload, followed by optional zero padding, as a byte stream with a valid/ready handshake. It sits between the ARP control logic (request/reply decision) and the Ethernet frame builder, which prepends the MAC header with EtherType 0x0806.

Parameters:
PAD_LEN, 18, number of 0x00 bytes appended after the 28-byte payload (18 gives the 46-byte minimum Ethernet payload; 0 disables padding). Legal range 0..63.

Ports:
aclk  input  1  clock
areset  input  1  synchronous reset, active-high
arp_tx_start  input  1  single-cycle start strobe; sampled only in IDLE
arp_oper  input  1  operation select: 0 = request (OPER 0x0001), 1 = reply (OPER 0x0002); latched at start
mac_s_addr  input  48  own MAC (SHA); latched at start
ip_s_addr  input  32  own IP (SPA); latched at start
mac_d_addr  input  48  target MAC (THA, reply only); latched at start
ip_d_addr  input  32  target IP (TPA); latched at start
data_out  output  8  stream byte
data_valid  output  1  data_out valid
data_ready  input  1  downstream accepts byte
data_last  output  1  marks final byte (last payload byte if PAD_LEN=0, else last pad byte)
arp_tx_busy  output  1  high from the cycle after start acceptance until the final transfer
arp_tx_done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (areset=1 at a clock edge): state IDLE; data_out=0, data_valid=0, data_last=0, arp_tx_busy=0, arp_tx_done=0; byte counter=0.
- Transfer: a byte moves on a clock edge when data_valid && data_ready. While data_valid=1 && data_ready=0, data_out and data_last hold stable. data_valid never drops mid-frame.
- Start: in IDLE with arp_tx_start=1 at edge N, latch all inputs. At N+1: data_valid=1, arp_tx_busy=1, data_out=byte 0. Start is ignored while busy. Input changes after latching have no effect on the frame in progress.
- Byte order is big-endian (MSB byte first) for every field:
  - HTYPE: bytes 0-1 = 0x00 0x01
  - PTYPE: bytes 2-3 = 0x08 0x00
  - HLEN: byte 4 = 0x06
  - PLEN: byte 5 = 0x04
  - OPER: bytes 6-7 = 0x00, then 0x01 or 0x02
  - SHA: bytes 8-13
  - SPA: bytes 14-17
  - THA: bytes 18-23 = 00:00:00:00:00:00 for a request, latched mac_d_addr for a reply
  - TPA: bytes 24-27
  - PAD: bytes 28..27+PAD_LEN = 0x00
- States: IDLE -> HEADER (8 bytes) -> MAC_SOURCE (6) -> IP_SOURCE (4) -> MAC_DESTINATION (6) -> IP_DESTINATION (4) -> PAD (PAD_LEN; skipped when PAD_LEN=0) -> IDLE.
  - Each state advances only on a transfer of its last byte.
  - A 6-bit counter indexes the byte within the current state and clears on each state change.
- End of frame: data_last=1 exactly on the final byte. On the edge that transfers it:
  - next cycle: data_valid=0, arp_tx_busy=0, arp_tx_done=1 for one cycle, state IDLE.
  - arp_tx_start in that done cycle is accepted (back-to-back frames, one idle cycle between them).
- Frame length: 28+PAD_LEN transfers. With data_ready held high, latency from the start edge to the done pulse is 28+PAD_LEN+1 cycles.
- Reset mid-frame: abort immediately. Next cycle data_valid=0 and busy=0; no done pulse; the partial frame is not resumed.
- Start and reset in the same cycle: reset wins.

Test Plan:
- Request: mac_s=02:00:00:00:00:01, ip_s=C0A8010A, ip_d=C0A80101, oper=0, ready=1, PAD_LEN=18 -> 46 bytes: 00 01 08 00 06 04 00 01 02 00 00 00 00 01 C0 A8 01 0A, six 00 bytes, C0 A8 01 01, 18x00; data_last on byte 45; done 47 cycles after start.
- Reply: oper=1, mac_d=AA:BB:CC:DD:EE:FF -> byte 7=0x02, bytes 18-23=AA BB CC DD EE FF, remaining bytes per field values.
- Backpressure: deassert data_ready for 3 cycles at byte 10 and at byte 45 -> data_out and data_last held stable; the byte sequence is identical to the no-stall run; done follows the final accepted byte.
- Busy/start interaction: pulse start mid-frame -> ignored, output unchanged; pulse start in the done cycle -> second frame starts next cycle; changing input addresses mid-frame does not alter the current frame.
- Reset mid-frame: areset at byte 15 -> next cycle data_valid=0 and busy=0, no done pulse; a new start produces a complete frame from byte 0.
- PAD_LEN=0 build: 28-byte frame, data_last on byte 27 (TPA LSB).
